// File: rtl/clock_time_keeper.sv
// Time-of-day keeper: 1 Hz prescaler, BCD hour/minute/second counters and a
// RUN / SET_HOUR / SET_MIN mode machine driven by debounced button pulses.
module clock_time_keeper #(
    parameter int DIV = 50000000,
    parameter int CW  = 26
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [2:0]  BTN,
    output logic [7:0]  HOUR,
    output logic [7:0]  MIN,
    output logic [7:0]  SEC,
    output logic [1:0]  MODE,
    output logic        BLINK
);

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        SET_HOUR = 2'b01,
        SET_MIN  = 2'b10,
        UNUSED   = 2'b11
    } mode_t;

    localparam logic [CW-1:0] CNT_MAX  = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(DIV / 2);

    // Two-digit BCD increment for minutes/seconds: 00..59, wraps to 00.
    function automatic logic [7:0] bcd_inc60(input logic [7:0] v);
        logic [7:0] r;
        if (v[3:0] == 4'd9) begin
            if (v[7:4] == 4'd5) begin
                r = 8'h00;
            end else begin
                r = {v[7:4] + 4'd1, 4'd0};
            end
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

    // Two-digit BCD increment for hours: units stop at 3 once tens reach 2.
    function automatic logic [7:0] bcd_inc24(input logic [7:0] v);
        logic [7:0] r;
        if (v == 8'h23) begin
            r = 8'h00;
        end else if (v[3:0] == 4'd9) begin
            r = {v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

    mode_t         r_mode;
    mode_t         w_mode_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic [7:0]    r_hour;
    logic [7:0]    r_min;
    logic [7:0]    r_sec;
    logic          r_blink;
    logic [7:0]    w_hour_nxt;
    logic [7:0]    w_min_nxt;
    logic [7:0]    w_sec_nxt;
    logic          w_blink_nxt;
    logic          w_tick;
    logic          w_run;
    logic          w_set_hour;
    logic          w_set_min;
    logic          w_run_tick;
    logic          w_set_inc;

    assign w_tick     = (r_cnt == CNT_MAX);
    // A mode press steals the tick; a seconds clear suppresses it and any carry.
    assign w_run_tick = w_run & w_tick & ~BTN[0] & ~BTN[2];
    assign w_set_inc  = BTN[1] & ~BTN[0];

    // Mode state register
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_mode <= RUN;
        end else begin
            r_mode <= w_mode_nxt;
        end
    end

    // Mode next-state logic
    always_comb begin
        w_mode_nxt = r_mode;
        case (r_mode)
            RUN: begin
                if (BTN[0]) begin
                    w_mode_nxt = SET_HOUR;
                end else begin
                    w_mode_nxt = RUN;
                end
            end
            SET_HOUR: begin
                if (BTN[0]) begin
                    w_mode_nxt = SET_MIN;
                end else begin
                    w_mode_nxt = SET_HOUR;
                end
            end
            SET_MIN: begin
                if (BTN[0]) begin
                    w_mode_nxt = RUN;
                end else begin
                    w_mode_nxt = SET_MIN;
                end
            end
            default: w_mode_nxt = RUN;
        endcase
    end

    // Mode decode
    always_comb begin
        w_run      = 1'b0;
        w_set_hour = 1'b0;
        w_set_min  = 1'b0;
        case (r_mode)
            RUN:      w_run      = 1'b1;
            SET_HOUR: w_set_hour = 1'b1;
            SET_MIN:  w_set_min  = 1'b1;
            default:  w_run      = 1'b0;
        endcase
    end

    // Prescaler and time-field next values
    always_comb begin
        w_cnt_nxt   = r_cnt;
        w_sec_nxt   = r_sec;
        w_min_nxt   = r_min;
        w_hour_nxt  = r_hour;
        w_blink_nxt = (r_mode != RUN) && (r_cnt < CNT_HALF);

        if (BTN[2]) begin
            w_cnt_nxt = {CW{1'b0}};
        end else if (w_tick) begin
            w_cnt_nxt = {CW{1'b0}};
        end else begin
            w_cnt_nxt = r_cnt + {{(CW-1){1'b0}}, 1'b1};
        end

        if (BTN[2]) begin
            w_sec_nxt = 8'h00;
        end else if (w_run_tick) begin
            w_sec_nxt = bcd_inc60(r_sec);
        end else begin
            w_sec_nxt = r_sec;
        end

        if (w_run_tick && (r_sec == 8'h59)) begin
            w_min_nxt = bcd_inc60(r_min);
        end else if (w_set_min && w_set_inc) begin
            w_min_nxt = bcd_inc60(r_min);
        end else begin
            w_min_nxt = r_min;
        end

        if (w_run_tick && (r_sec == 8'h59) && (r_min == 8'h59)) begin
            w_hour_nxt = bcd_inc24(r_hour);
        end else if (w_set_hour && w_set_inc) begin
            w_hour_nxt = bcd_inc24(r_hour);
        end else begin
            w_hour_nxt = r_hour;
        end
    end

    // Datapath registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_cnt   <= {CW{1'b0}};
            r_sec   <= 8'h00;
            r_min   <= 8'h00;
            r_hour  <= 8'h00;
            r_blink <= 1'b0;
        end else begin
            r_cnt   <= w_cnt_nxt;
            r_sec   <= w_sec_nxt;
            r_min   <= w_min_nxt;
            r_hour  <= w_hour_nxt;
            r_blink <= w_blink_nxt;
        end
    end

    assign HOUR  = r_hour;
    assign MIN   = r_min;
    assign SEC   = r_sec;
    assign MODE  = r_mode;
    assign BLINK = r_blink;

endmodule

// File: tb/tb_clock_time_keeper.sv
// Self-checking bench for clock_time_keeper with DIV=10; a seconds-of-day
// reference model predicts every output cycle by cycle.
module tb_clock_time_keeper;

    localparam int DIV = 10;

    logic        CLK;
    logic        RST;
    logic [2:0]  BTN;
    logic [7:0]  HOUR;
    logic [7:0]  MIN;
    logic [7:0]  SEC;
    logic [1:0]  MODE;
    logic        BLINK;
    logic [26:0] obs;

    int n_checks;
    int n_errors;

    int   m_h;
    int   m_m;
    int   m_s;
    int   m_mode;
    int   m_cnt;
    logic m_blink;

    clock_time_keeper #(.DIV(DIV), .CW(4)) dut (
        .CLK   (CLK),
        .RST   (RST),
        .BTN   (BTN),
        .HOUR  (HOUR),
        .MIN   (MIN),
        .SEC   (SEC),
        .MODE  (MODE),
        .BLINK (BLINK)
    );

    assign obs = {HOUR, MIN, SEC, MODE, BLINK};

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [7:0] bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic logic [26:0] exp_vec();
        return {bcd(m_h), bcd(m_m), bcd(m_s), 2'(m_mode), m_blink};
    endfunction

    // Reference model: one clock edge worth of behaviour
    function automatic void model_edge(input logic [2:0] b, input logic rst);
        int   tod;
        logic tick;
        logic nb;
        if (rst) begin
            m_h = 0; m_m = 0; m_s = 0; m_mode = 0; m_cnt = 0; m_blink = 1'b0;
        end else begin
            tick = (m_cnt == DIV - 1);
            nb   = (m_mode != 0) && (m_cnt < DIV / 2);
            if (m_mode == 0 && tick && !b[0] && !b[2]) begin
                tod = (m_h * 3600 + m_m * 60 + m_s + 1) % 86400;
                m_h = tod / 3600;
                m_m = (tod / 60) % 60;
                m_s = tod % 60;
            end
            if (m_mode == 1 && b[1] && !b[0]) m_h = (m_h + 1) % 24;
            if (m_mode == 2 && b[1] && !b[0]) m_m = (m_m + 1) % 60;
            if (b[2]) m_s = 0;
            m_cnt = b[2] ? 0 : (m_cnt + 1) % DIV;
            if (m_mode == 3) m_mode = 0;
            else if (b[0]) m_mode = (m_mode + 1) % 3;
            m_blink = nb;
        end
    endfunction

    task automatic step(input logic [2:0] b);
        BTN = b;
        @(posedge CLK);
        model_edge(b, RST);
        @(negedge CLK);
        BTN = 3'b000;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        step(3'b000);
        step(3'b000);
        n_checks++;
        if (obs !== 27'd0) begin
            n_errors++;
            $display("FAIL reset_state: got %h expected %h", obs, 27'd0);
        end
        RST = 1'b0;
    endtask

    task automatic test_run();
        logic blink_seen;
        blink_seen = 1'b0;
        for (int i = 0; i < 600; i++) begin
            step(3'b000);
            blink_seen = blink_seen | BLINK;
            n_checks++;
            if (obs !== exp_vec()) begin
                n_errors++;
                $display("FAIL run_cycle%0d: got %h expected %h", i, obs, exp_vec());
            end
        end
        n_checks++;
        if ({HOUR, MIN, SEC, MODE} !== {8'h00, 8'h01, 8'h00, 2'b00}) begin
            n_errors++;
            $display("FAIL run_600: got %h expected 000100 mode 0", {HOUR, MIN, SEC, MODE});
        end
        n_checks++;
        if (blink_seen !== 1'b0) begin
            n_errors++;
            $display("FAIL run_blink: got %b expected 0", blink_seen);
        end
    endtask

    task automatic test_rollover();
        step(3'b001);
        for (int k = 0; k < 30 && m_h != 23; k++) step(3'b010);
        step(3'b001);
        for (int k = 0; k < 70 && m_m != 59; k++) step(3'b010);
        step(3'b001);
        step(3'b100);
        repeat (580) step(3'b000);
        n_checks++;
        if ({HOUR, MIN, SEC, MODE} !== {8'h23, 8'h59, 8'h58, 2'b00}) begin
            n_errors++;
            $display("FAIL preload: got %h expected 235958 mode 0", {HOUR, MIN, SEC, MODE});
        end
        repeat (9) step(3'b000);
        n_checks++;
        if (SEC !== 8'h58) begin
            n_errors++;
            $display("FAIL tick_early: got %h expected 58", SEC);
        end
        step(3'b000);
        n_checks++;
        if ({HOUR, MIN, SEC} !== {8'h23, 8'h59, 8'h59}) begin
            n_errors++;
            $display("FAIL tick1: got %h expected 235959", {HOUR, MIN, SEC});
        end
        repeat (10) step(3'b000);
        n_checks++;
        if ({HOUR, MIN, SEC} !== 24'h000000) begin
            n_errors++;
            $display("FAIL midnight_wrap: got %h expected 000000", {HOUR, MIN, SEC});
        end
        n_checks++;
        if (obs !== exp_vec()) begin
            n_errors++;
            $display("FAIL rollover_model: got %h expected %h", obs, exp_vec());
        end
    endtask

    task automatic test_set_hour();
        logic prev;
        int   toggles;
        step(3'b001);
        n_checks++;
        if (MODE !== 2'b01) begin
            n_errors++;
            $display("FAIL enter_set_hour: got %b expected 01", MODE);
        end
        toggles = 0;
        for (int i = 0; i < 21; i++) begin
            step(3'b000);
            if (i > 0 && BLINK !== prev) toggles++;
            prev = BLINK;
            n_checks++;
            if (obs !== exp_vec()) begin
                n_errors++;
                $display("FAIL blink_cycle%0d: got %h expected %h", i, obs, exp_vec());
            end
        end
        n_checks++;
        if (toggles != 4) begin
            n_errors++;
            $display("FAIL blink_toggles: got %0d expected 4", toggles);
        end
        repeat (25) step(3'b010);
        n_checks++;
        if ({HOUR, MIN} !== {8'h01, 8'h00}) begin
            n_errors++;
            $display("FAIL hour_wrap: got %h expected 0100", {HOUR, MIN});
        end
    endtask

    task automatic test_set_min();
        int start_m;
        int start_s;
        step(3'b001);
        start_m = m_m;
        start_s = m_s;
        repeat (60) step(3'b010);
        n_checks++;
        if ({HOUR, MIN, MODE} !== {8'h01, bcd(start_m), 2'b10}) begin
            n_errors++;
            $display("FAIL min_60: got %h expected %h", {HOUR, MIN, MODE}, {8'h01, bcd(start_m), 2'b10});
        end
        repeat (40) step(3'b000);
        n_checks++;
        if (SEC !== bcd(start_s)) begin
            n_errors++;
            $display("FAIL sec_frozen: got %h expected %h", SEC, bcd(start_s));
        end
    endtask

    task automatic test_priority();
        int min_before;
        int k;
        step(3'b001);
        step(3'b001);
        step(3'b011);
        n_checks++;
        if ({MODE, HOUR} !== {2'b10, 8'h01}) begin
            n_errors++;
            $display("FAIL mode_vs_inc: got %h expected %h", {MODE, HOUR}, {2'b10, 8'h01});
        end
        step(3'b001);
        for (k = 0; k < 700 && !(m_s == 59 && m_cnt == DIV - 1); k++) step(3'b000);
        n_checks++;
        if (k >= 700) begin
            n_errors++;
            $display("FAIL wait_sec59: got timeout expected sec 59");
        end
        min_before = m_m;
        step(3'b100);
        n_checks++;
        if ({SEC, MIN} !== {8'h00, bcd(min_before)}) begin
            n_errors++;
            $display("FAIL clear_vs_tick: got %h expected %h", {SEC, MIN}, {8'h00, bcd(min_before)});
        end
        step(3'b001);
        step(3'b001);
        min_before = m_m;
        step(3'b110);
        n_checks++;
        if ({SEC, MIN} !== {8'h00, bcd((min_before + 1) % 60)}) begin
            n_errors++;
            $display("FAIL clear_and_inc: got %h expected %h", {SEC, MIN}, {8'h00, bcd((min_before + 1) % 60)});
        end
        step(3'b001);
    endtask

    task automatic test_random();
        int r;
        logic [2:0] b;
        for (int i = 0; i < 1500; i++) begin
            r = $urandom_range(0, 15);
            case (r)
                0:       b = 3'b001;
                1, 2:    b = 3'b010;
                3:       b = 3'b100;
                4:       b = 3'($urandom);
                default: b = 3'b000;
            endcase
            step(b);
            n_checks++;
            if (obs !== exp_vec()) begin
                n_errors++;
                $display("FAIL random_cycle%0d: got %h expected %h", i, obs, exp_vec());
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 4 && m_mode != 0; k++) step(3'b001);
        step(3'b100);
        repeat (560) step(3'b000);
        step(3'b001);
        for (int k = 0; k < 30 && m_h != 12; k++) step(3'b010);
        step(3'b001);
        for (int k = 0; k < 70 && m_m != 34; k++) step(3'b010);
        n_checks++;
        if ({HOUR, MIN, SEC, MODE} !== {8'h12, 8'h34, 8'h56, 2'b10}) begin
            n_errors++;
            $display("FAIL pre_reset: got %h expected 123456 mode 2", {HOUR, MIN, SEC, MODE});
        end
        RST = 1'b1;
        step(3'b111);
        n_checks++;
        if (obs !== 27'd0) begin
            n_errors++;
            $display("FAIL mid_reset: got %h expected %h", obs, 27'd0);
        end
        RST = 1'b0;
        step(3'b000);
        n_checks++;
        if (obs !== exp_vec()) begin
            n_errors++;
            $display("FAIL post_reset: got %h expected %h", obs, exp_vec());
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        RST = 1'b1;
        BTN = 3'b000;
        test_reset();
        test_run();
        test_rollover();
        test_set_hour();
        test_set_min();
        test_priority();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
